// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: loads a saturated BCD preset, decrements on
// tick through a decimal borrow chain, and reports RUN/DONE plus a DONE-entry strobe.
module bcd_down_timer #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    loadN,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] init,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    expired,
  output logic                    tc_pulse
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [W-1:0]   count_r;
  logic [W-1:0]   count_s;
  logic [W-1:0]   dec_s;
  logic           running_r;
  logic           expired_r;
  logic           tc_pulse_r;
  logic           tc_pulse_s;

  // Any digit above 9 in the preset is pinned to 9 so count stays pure BCD.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Ripple the borrow from digit 0 upward; a zero digit wraps to 9 and passes it on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign dec_s = bcd_dec(count_r);

  // Next-state, next-count and DONE-entry strobe; priority load > start/pause > tick.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    tc_pulse_s = 1'b0;
    if (enable) begin
      if (!loadN) begin
        count_s = clamp_bcd(init);
        state_s = IDLE;
      end else begin
        case (state_r)
          IDLE, PAUSED: begin
            if (start) begin
              if (count_r == {W{1'b0}}) begin
                state_s    = DONE;
                tc_pulse_s = 1'b1;
              end else begin
                state_s = RUN;
              end
            end else begin
              state_s = state_r;
            end
          end
          RUN: begin
            if (pause) begin
              state_s = PAUSED;
            end else if (tick) begin
              // A zero count cannot normally be in RUN; treat it as already expired.
              if (count_r == {W{1'b0}} || dec_s == {W{1'b0}}) begin
                count_s    = {W{1'b0}};
                state_s    = DONE;
                tc_pulse_s = 1'b1;
              end else begin
                count_s = dec_s;
              end
            end else begin
              state_s = RUN;
            end
          end
          DONE: begin
            count_s = {W{1'b0}};
            state_s = DONE;
          end
          default: begin
            count_s = {W{1'b0}};
            state_s = IDLE;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, count and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= {W{1'b0}};
      running_r  <= 1'b0;
      expired_r  <= 1'b0;
      tc_pulse_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      running_r  <= (state_s == RUN);
      expired_r  <= (state_s == DONE);
      tc_pulse_r <= tc_pulse_s;
    end
  end

  assign count    = count_r;
  assign running  = running_r;
  assign expired  = expired_r;
  assign tc_pulse = tc_pulse_r;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a decimal-integer reference model.
module tb_bcd_down_timer;

  localparam int ND = 2;
  localparam int W  = 4 * ND;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         loadN;
  logic         start;
  logic         pause;
  logic         tick;
  logic [W-1:0] init;
  logic [W-1:0] count;
  logic         running;
  logic         expired;
  logic         tc_pulse;

  int n_cmp;
  int n_err;

  // Reference model: plain decimal value plus phase (0 idle, 1 run, 2 paused, 3 done).
  int m_val;
  int m_st;
  bit m_tc;

  typedef struct packed {
    logic         en;
    logic         ld;
    logic         st;
    logic         ps;
    logic         tk;
    logic [W-1:0] ini;
    logic [W-1:0] e_count;
    logic         e_run;
    logic         e_exp;
    logic         e_tc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  bcd_down_timer #(.NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .loadN    (loadN),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .init     (init),
    .count    (count),
    .running  (running),
    .expired  (expired),
    .tc_pulse (tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int preset_value(input logic [W-1:0] p);
    int v;
    int scale;
    int d;
    v = 0;
    scale = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_tc = 1'b0;
    if (enable) begin
      if (!loadN) begin
        m_val = preset_value(init);
        m_st  = 0;
      end else if (m_st == 0 || m_st == 2) begin
        if (start) begin
          if (m_val == 0) begin
            m_st = 3;
            m_tc = 1'b1;
          end else begin
            m_st = 1;
          end
        end
      end else if (m_st == 1) begin
        if (pause) begin
          m_st = 2;
        end else if (tick) begin
          m_val = m_val - 1;
          if (m_val == 0) begin
            m_st = 3;
            m_tc = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    check("count", count, to_bcd(m_val));
    check("running", W'(running), W'(m_st == 1));
    check("expired", W'(expired), W'(m_st == 3));
    check("tc_pulse", W'(tc_pulse), W'(m_tc));
  endtask

  // Drive one cycle of inputs, clock it, and compare against the model.
  task automatic apply(input logic en, input logic ld, input logic st, input logic ps,
                       input logic tk, input logic [W-1:0] ini);
    enable = en;
    loadN  = ld;
    start  = st;
    pause  = ps;
    tick   = tk;
    init   = ini;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Assert reset between edges and verify it takes effect before any clock.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    m_val = 0;
    m_st  = 0;
    m_tc  = 1'b0;
    check("rst_count", count, '0);
    check("rst_running", W'(running), '0);
    check("rst_expired", W'(expired), '0);
    check("rst_tc", W'(tc_pulse), '0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    m_val  = 0;
    m_st   = 0;
    m_tc   = 1'b0;
    reset  = 1'b1;
    enable = 1'b0;
    loadN  = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    tick   = 1'b0;
    init   = '0;

    //          en    ld    st    ps    tk    init   count  run   exp   tc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h19, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h35, 8'h35, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h35, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h35, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h35, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h35, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h35, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h35, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h34, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAF, 8'h99, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h57, 8'h57, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h57, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h57, 1'b0, 1'b0, 1'b0};

    #12;
    check("init_count", count, '0);
    check("init_running", W'(running), '0);
    check("init_expired", W'(expired), '0);
    check("init_tc", W'(tc_pulse), '0);
    @(negedge clk);
    reset = 1'b0;

    // Full countdown from 12 through expiry, then ticks held off in DONE.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      check("cd_count", count, to_bcd(12 - k));
      check("cd_running", W'(running), W'(k < 12));
      check("cd_tc", W'(tc_pulse), W'(k == 12));
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      check("done_count", count, 8'h00);
      check("done_tc", W'(tc_pulse), '0);
      check("done_expired", W'(expired), 8'h01);
    end

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].en, tbl[i].ld, tbl[i].st, tbl[i].ps, tbl[i].tk, tbl[i].ini);
      check($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
      check($sformatf("tbl%0d_running", i), W'(running), W'(tbl[i].e_run));
      check($sformatf("tbl%0d_expired", i), W'(expired), W'(tbl[i].e_exp));
      check($sformatf("tbl%0d_tc", i), W'(tc_pulse), W'(tbl[i].e_tc));
    end

    // Clock-enable freeze: ticks and load ignored, counting resumes afterwards.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h25);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
      check("hold_count", count, 8'h24);
      check("hold_running", W'(running), 8'h01);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
    check("hold_noload", count, 8'h24);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("resume_count", count, 8'h23);

    // Asynchronous reset mid-count at 07, then a tick in IDLE does nothing.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pre_rst_count", count, 8'h07);
    async_reset();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("post_rst_count", count, 8'h00);
    check("post_rst_running", W'(running), 8'h00);

    // Random traffic against the model, with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(999, 0) < 3) begin
        async_reset();
      end else begin
        apply(($urandom_range(9, 0) != 0),
              ($urandom_range(19, 0) != 0),
              ($urandom_range(9, 0) == 0),
              ($urandom_range(11, 0) == 0),
              ($urandom_range(9, 0) < 5),
              W'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Multi-digit BCD countdown timer for the game round clock and race-start countdown. It is the count-down counterpart of the team's BCD up-counter digit. It loads a BCD preset, decrements once per external tick with a decimal borrow chain, and flags expiry with a level and a one-cycle pulse. It feeds the seven-segment and HUD display logic and the game-over control FSM.

Parameters:
NUM_DIGITS, 2, number of BCD digits; count width is 4*NUM_DIGITS (legal range 1..4).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  global clock-enable; when low, all state holds.
loadN  input  1  active-low synchronous load of init (qualified by enable).
start  input  1  begin or resume counting (level-sampled each cycle).
pause  input  1  suspend counting (level-sampled each cycle).
tick  input  1  one-cycle decrement strobe, e.g. the 1 Hz one_sec pulse.
init  input  4*NUM_DIGITS  BCD preset; digit 0 in bits [3:0].
count  output  4*NUM_DIGITS  current BCD value, registered.
running  output  1  high while in state RUN.
expired  output  1  high while in state DONE.
tc_pulse  output  1  one-cycle strobe on entry to DONE.

Behaviour:
- Reset (asynchronous, any time, including mid-count): count=0, state=IDLE, running=0, expired=0, tc_pulse=0.
- States: IDLE, RUN, PAUSED, DONE. running=(state==RUN) and expired=(state==DONE), both registered.
- enable=0: count and state hold, tc_pulse=0. All inputs below are evaluated only when enable=1.
- Per-cycle priority is loadN > start/pause > tick.
- loadN=0: from any state, count<=init and state<=IDLE. Any init digit >9 is stored as 9.
- IDLE or PAUSED, start=1: if count==0, go to DONE and assert tc_pulse; else go to RUN. No decrement in this cycle. pause has no effect in IDLE or PAUSED.
- RUN, pause=1: go to PAUSED. pause wins over a simultaneous tick (no decrement). start in RUN is ignored.
- RUN, tick=1, pause=0: decrement by 1 in BCD.
  - Digit i becomes digit-1 if nonzero. Otherwise it becomes 9 and borrows from digit i+1.
  - Decrement latency is 1 cycle: count reflects the tick on the next clock edge.
  - If the decremented value is 0: count<=0, state<=DONE, tc_pulse=1 in that same cycle.
- tick outside RUN: ignored.
- DONE: count stays 0 with no wrap to 99. start, pause and tick are ignored. Exit only through loadN=0 (to IDLE) or reset.
- tc_pulse is high for exactly one cycle per DONE entry, otherwise 0. It never reasserts while remaining in DONE.
- count never holds a non-BCD digit.

Test Plan:
1. Reset, loadN=0 with init=8'h12, start, 12 ticks -> count sequence 12,11,10,09,...,01,00. running=1 until the last tick. expired=1 and tc_pulse one cycle on 01->00. Further ticks leave count=00.
2. Load 8'h20, start, 1 tick -> count 8'h19 (borrow: digit0 0->9, digit1 2->1). Load 8'h00, start -> immediate DONE with tc_pulse=1 and no ticks.
3. RUN at 8'h35: pause and tick in the same cycle -> PAUSED, count stays 35. Three ticks -> still 35. start -> RUN; next tick -> 34.
4. enable=0 while in RUN with ticks applied -> count and state frozen. loadN=0 while enable=0 -> no load. enable=1 -> counting resumes from the held value.
5. init=8'hAF, loadN=0 -> count=8'h99. loadN=0 while in RUN at 8'h40 -> count=init, state IDLE, running=0, no tc_pulse.
6. Assert reset asynchronously (between clock edges) during RUN at 8'h07 -> count=00, running=0, expired=0 immediately. After reset release, tick -> no change (IDLE).
